// File: rtl/ifetch_unit_if.sv
// Instruction-fetch bus bundle: memory request/response channel and the
// held-instruction channel toward decode. "master" is the fetch unit side.
interface ifetch_unit_if;
   // Handshake rule for both channels: a transfer happens on a rising edge
   // where valid and ready are both 1; the holder of valid keeps its payload
   // stable until then. The response channel has no ready: the fetcher is
   // always able to take the single outstanding response.
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic [31:0] Instruction;
   logic [63:0] inst_pc;
   logic        inst_ready;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, Instruction, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, Instruction, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
   );
endinterface

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetcher: request, wait for the word, hold it
// for decode, then load the PC supplied by the next-PC logic.
module ifetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                 CLK,
   input  logic                 resetl,
   input  logic [63:0]          NextPC,
   output logic [63:0]          CurrentPC,
   output logic                 fetch_fault,
   output logic [31:0]          inst_count,
   output logic [1:0]           dbgState,
   ifetch_unit_if.master        bus
);

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } fetchState_e;

   fetchState_e state;
   logic [63:0] pcReg;
   logic [31:0] instrReg;
   logic [31:0] instCount;
   logic        faultReg;
   logic        reqValidReg;
   logic        instValidReg;

   // Request/instruction valids are registered alongside the state so they
   // are exact functions of it: req only in REQ, inst only in HOLD.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state        <= ST_REQ;
         pcReg        <= RESET_PC;
         instrReg     <= 32'h0;
         instCount    <= 32'h0;
         faultReg     <= 1'b0;
         reqValidReg  <= 1'b1;
         instValidReg <= 1'b0;
      end else begin
         case (state)
            ST_REQ: begin
               if (bus.imem_req_ready) begin
                  state       <= ST_WAIT;
                  reqValidReg <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (bus.imem_rsp_valid) begin
                  state        <= ST_HOLD;
                  instrReg     <= bus.imem_rsp_data;
                  instValidReg <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.inst_ready) begin
                  instValidReg <= 1'b0;
                  instCount    <= instCount + 32'd1;
                  // A misaligned successor PC is never fetched; the PC keeps
                  // the faulting instruction's address for diagnosis.
                  if (NextPC[1:0] == 2'b00) begin
                     state       <= ST_REQ;
                     pcReg       <= NextPC;
                     reqValidReg <= 1'b1;
                  end else begin
                     state    <= ST_FAULT;
                     faultReg <= 1'b1;
                  end
               end
            end
            ST_FAULT: begin
               state <= ST_FAULT;
            end
            default: begin
               state <= ST_FAULT;
            end
         endcase
      end
   end

   assign CurrentPC          = pcReg;
   assign fetch_fault        = faultReg;
   assign inst_count         = instCount;
   assign dbgState           = state;
   assign bus.imem_req_valid = reqValidReg;
   assign bus.imem_req_addr  = pcReg;
   assign bus.inst_valid     = instValidReg;
   assign bus.Instruction    = instrReg;
   // PC only moves on acceptance, so it is the held instruction's address.
   assign bus.inst_pc        = pcReg;

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0: the PC value loaded on reset.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 resetl  input  1  asynchronous, active-low reset.
REQ-004 NextPC  input  64  next-PC value from the NextPClogic stage, computed combinationally from CurrentPC and the held instruction.
REQ-005 CurrentPC  output  64  the PC register; drives NextPClogic.CurrentPC.
REQ-006 imem_req_valid  output  1  fetch request to instruction memory.
REQ-007 imem_req_addr  output  64  fetch address; always equals CurrentPC.
REQ-008 imem_req_ready  input  1  memory accepts the request.
REQ-009 imem_rsp_valid  input  1  response data valid.
REQ-010 imem_rsp_data  input  32  fetched instruction word.
REQ-011 inst_valid  output  1  Instruction/inst_pc valid to decode.
REQ-012 Instruction  output  32  held instruction word.
REQ-013 inst_pc  output  64  PC of the held instruction.
REQ-014 inst_ready  input  1  decode consumes the held instruction this cycle.
REQ-015 fetch_fault  output  1  sticky misaligned-PC fault flag.
REQ-016 inst_count  output  32  number of instructions consumed by decode.

Function
REQ-017 The FSM SHALL have states REQ, WAIT, HOLD, and FAULT; the encoding is free.
REQ-018 REQ: imem_req_valid=1; if imem_req_ready=1, go to WAIT; otherwise stay in REQ with address held stable.
REQ-019 WAIT: imem_req_valid=0; if imem_rsp_valid=1, capture imem_rsp_data into Instruction and go to HOLD; otherwise stay in WAIT with no timeout.
REQ-020 imem_rsp_valid SHALL be ignored in every state other than WAIT, and SHALL NOT be sampled on the same cycle as the REQ handshake.
REQ-021 HOLD: inst_valid=1 with Instruction and inst_pc stable; if inst_ready=0, stay in HOLD.
REQ-022 HOLD with inst_ready=1: sample NextPC. If NextPC[1:0]==0, load PC<=NextPC, increment inst_count, and go to REQ.
REQ-023 HOLD with inst_ready=1 and NextPC[1:0]!=0: PC is unchanged, inst_count still increments, fetch_fault<=1, and go to FAULT.
REQ-024 FAULT: imem_req_valid=0, inst_valid=0, fetch_fault=1; the only exit is reset.
REQ-025 inst_valid SHALL be 1 only in HOLD; imem_req_valid SHALL be 1 only in REQ.
REQ-026 NextPC is sampled only at the HOLD acceptance edge; the value at all other times is don't-care.
REQ-027 Minimum throughput is one instruction per 3 cycles (REQ handshake, WAIT response, HOLD accept) with zero-wait memory and decode.
REQ-028 inst_count is 32-bit unsigned and SHALL wrap from FFFF_FFFF to 0 without side effects.
REQ-029 PC arithmetic is not performed here; NextPC is the full 64-bit PC, loaded unmodified.
REQ-030 inst_pc SHALL equal CurrentPC while in HOLD, because the PC updates only on acceptance.

Reset
REQ-031 When resetl=0, the block SHALL immediately, without waiting for CLK: enter REQ, set PC=RESET_PC, inst_count=0, fetch_fault=0, Instruction=0, and inst_valid=0.
REQ-032 Reset asserted mid-operation (REQ/WAIT/HOLD/FAULT) SHALL abandon any outstanding fetch; instruction memory shares resetl and drops in-flight responses.
REQ-033 After deassertion, imem_req_valid=1 with imem_req_addr=RESET_PC starting in the first cycle.
REQ-034 At most one fetch SHALL ever be outstanding.

Verification
REQ-035 Reset with RESET_PC=16; ready/rsp always high; rsp_data=32'hAAAA_0001; NextPC=24; inst_ready=1 -> CurrentPC 16, then 24 three cycles later; inst_count=1; Instruction=AAAA_0001 with inst_pc=16 in HOLD.
REQ-036 Hold imem_req_ready=0 for 4 cycles, then rsp delayed 5 cycles -> req_addr stays 16, inst_valid=0 throughout; HOLD is entered exactly one cycle after rsp_valid.
REQ-037 Decode stall: inst_ready=0 for 6 cycles, with NextPC changing each cycle (90, 20, 32) -> Instruction and inst_pc stable; PC loads only the value present at the accept edge (32).
REQ-038 Stray imem_rsp_valid pulses in REQ and HOLD -> Instruction unchanged and no state change.
REQ-039 NextPC=26 at accept -> fetch_fault=1, FAULT held with no requests, CurrentPC unchanged; reset clears fault and restarts at RESET_PC.
REQ-040 Async reset pulse asserted mid-WAIT between clock edges -> outputs return to reset values before the next edge; inst_count preloaded to FFFF_FFFF wraps to 0 on the next accept.
